// File: rtl/quad_decoder_vel.sv
`timescale 1ns/1ps
// Quadrature encoder front end: synchroniser, glitch filter, 4x decode into a
// modulo-CPR position with index homing, and windowed scaled velocity.
module quad_decoder_vel #(
  parameter int POS_W     = 16,
  parameter int CPR       = 1498,
  parameter int SYNC_STG  = 2,
  parameter int FILT_LEN  = 3,
  parameter int WIN_LOG2  = 17,
  parameter int VEL_W     = 16,
  parameter int VEL_NUM   = 29,
  parameter int VEL_SHIFT = 3,
  parameter int INDEX_RST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    quad_a,
  input  logic                    quad_b,
  input  logic                    quad_i,
  input  logic                    clr_pos,
  input  logic                    err_clr,
  output logic [POS_W-1:0]        pos,
  output logic                    dir,
  output logic signed [VEL_W-1:0] vel,
  output logic                    vel_valid,
  output logic                    index_seen,
  output logic                    err
);

  localparam int FCW  = $clog2(FILT_LEN + 1);
  localparam int BCW  = $clog2(SYNC_STG + 1);
  localparam int PW   = VEL_W + $clog2(VEL_NUM) + 1;
  localparam int VMAX = 2**(VEL_W-1) - 1;
  localparam logic signed [VEL_W:0] SMAX = (VEL_W+1)'(VMAX);
  localparam logic signed [VEL_W:0] SMIN = -SMAX;

  // Bit order everywhere in the input path: [0]=A, [1]=B, [2]=I
  logic [2:0]     r_sync [SYNC_STG];
  logic [2:0]     w_sync;
  logic [BCW-1:0] r_boot;
  logic           w_boot_done;
  logic           r_filt_ok;
  logic [2:0]     w_filt;
  logic [2:0]     r_prev;
  logic           r_prev_ok;

  assign w_sync      = r_sync[SYNC_STG-1];
  assign w_boot_done = (r_boot == BCW'(SYNC_STG));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STG; k++) r_sync[k] <= '0;
      r_boot    <= '0;
      r_filt_ok <= 1'b0;
      r_prev    <= '0;
      r_prev_ok <= 1'b0;
    end else begin
      r_sync[0] <= {quad_i, quad_b, quad_a};
      for (int k = 1; k < SYNC_STG; k++) r_sync[k] <= r_sync[k-1];
      if (!w_boot_done) r_boot <= r_boot + BCW'(1);
      if (w_boot_done) r_filt_ok <= 1'b1;
      r_prev    <= w_filt;
      r_prev_ok <= r_filt_ok;
    end
  end

  // Once the synchroniser has filled, the filter adopts its value directly so
  // the pins' idle levels never look like a transition.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_filt
      logic [FCW-1:0] r_cnt;
      logic           r_f;
      assign w_filt[gi] = r_f;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
          r_f   <= 1'b0;
        end else if (!r_filt_ok) begin
          r_cnt <= '0;
          if (w_boot_done) r_f <= w_sync[gi];
        end else if (w_sync[gi] != r_f) begin
          if (r_cnt == FCW'(FILT_LEN - 1)) begin
            r_f   <= w_sync[gi];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + FCW'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  endgenerate

  // Gray phase {A, A^B} counts 0..3 along the "down" direction
  logic [1:0] w_gc, w_gp, w_d;
  logic       w_up, w_down, w_ill, w_idx_rise;

  assign w_gc       = {w_filt[0], w_filt[0] ^ w_filt[1]};
  assign w_gp       = {r_prev[0], r_prev[0] ^ r_prev[1]};
  assign w_d        = w_gc - w_gp;
  assign w_down     = r_prev_ok && (w_d == 2'd1);
  assign w_up       = r_prev_ok && (w_d == 2'd3);
  assign w_ill      = r_prev_ok && (w_d == 2'd2);
  assign w_idx_rise = r_prev_ok && w_filt[2] && !r_prev[2];

  logic [POS_W-1:0] r_pos;
  logic             r_dir, r_seen, r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos  <= '0;
      r_dir  <= 1'b0;
      r_seen <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (en) begin
        if (clr_pos)
          r_pos <= '0;
        else if ((INDEX_RST != 0) && w_idx_rise)
          r_pos <= '0;
        else if (w_up)
          r_pos <= (r_pos == POS_W'(CPR - 1)) ? '0 : r_pos + POS_W'(1);
        else if (w_down)
          r_pos <= (r_pos == '0) ? POS_W'(CPR - 1) : r_pos - POS_W'(1);
        if (w_up || w_down) r_dir <= w_up;
      end
      if (en && clr_pos)   r_seen <= 1'b0;
      else if (w_idx_rise) r_seen <= 1'b1;
      if (w_ill)        r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  // Saturated step sum including this cycle's step, then sign-magnitude scaling
  logic signed [VEL_W:0]   w_sum;
  logic signed [VEL_W-1:0] w_sat;
  logic                    w_neg;
  logic [VEL_W-1:0]        w_mag, w_clmp, w_vel;
  logic [PW-1:0]           w_prod, w_shr;
  logic signed [VEL_W-1:0] r_acc;
  logic [VEL_W-1:0]        r_vel;
  logic [WIN_LOG2-1:0]     r_win;
  logic                    r_vv;

  always_comb begin
    w_sum = {r_acc[VEL_W-1], r_acc};
    if (w_up)        w_sum = w_sum + (VEL_W+1)'(1);
    else if (w_down) w_sum = w_sum - (VEL_W+1)'(1);
    if (w_sum > SMAX)      w_sat = SMAX[VEL_W-1:0];
    else if (w_sum < SMIN) w_sat = SMIN[VEL_W-1:0];
    else                   w_sat = w_sum[VEL_W-1:0];
    w_neg  = w_sat[VEL_W-1];
    w_mag  = w_neg ? (~w_sat + VEL_W'(1)) : w_sat;
    w_prod = PW'(w_mag) * PW'(VEL_NUM);
    w_shr  = w_prod >> VEL_SHIFT;
    w_clmp = (w_shr > PW'(VMAX)) ? VEL_W'(VMAX) : w_shr[VEL_W-1:0];
    w_vel  = w_neg ? (~w_clmp + VEL_W'(1)) : w_clmp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_vel <= '0;
      r_win <= '0;
      r_vv  <= 1'b0;
    end else begin
      r_vv <= 1'b0;
      if (en) begin
        r_win <= r_win + WIN_LOG2'(1);
        if (&r_win) begin
          r_vel <= w_vel;
          r_acc <= '0;
          r_vv  <= 1'b1;
        end else begin
          r_acc <= w_sat;
        end
      end
    end
  end

  assign pos        = r_pos;
  assign dir        = r_dir;
  assign vel        = r_vel;
  assign vel_valid  = r_vv;
  assign index_seen = r_seen;
  assign err        = r_err;

endmodule
